// File: rtl/univ_shift_reg.sv
// Universal register: hold, parallel load, shift, rotate, arithmetic shift and invert,
// with a registered serial-out bit and a saturating shift counter.
module univ_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qn,
    output logic                         so,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         full
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeLoad = 3'b001,
        ModeShl  = 3'b010,
        ModeShr  = 3'b011,
        ModeRol  = 3'b100,
        ModeRor  = 3'b101,
        ModeAsr  = 3'b110,
        ModeInv  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;
    logic             cnt_sat;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);
    assign cnt_sat  = (cnt_q == CW'(WIDTH));
    // Counter stops at WIDTH so full stays asserted under further shifts.
    assign cnt_inc  = cnt_sat ? cnt_q : cnt_q + CW'(1);

    // Next-state selection: clr beats en, en=0 holds, otherwise decode mode.
    always_comb begin
        q_d   = q_q;
        so_d  = so_q;
        cnt_d = cnt_q;
        if (clr) begin
            q_d   = RESET_VAL;
            so_d  = 1'b0;
            cnt_d = '0;
        end else if (en) begin
            unique case (mode_sel)
                ModeHold: begin
                end
                ModeLoad: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                ModeShl: begin
                    q_d   = {q_q[WIDTH-2:0], sin};
                    so_d  = q_q[WIDTH-1];
                    cnt_d = cnt_inc;
                end
                ModeShr: begin
                    q_d   = {sin, q_q[WIDTH-1:1]};
                    so_d  = q_q[0];
                    cnt_d = cnt_inc;
                end
                ModeRol: begin
                    q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d  = q_q[WIDTH-1];
                    cnt_d = cnt_inc;
                end
                ModeRor: begin
                    q_d   = {q_q[0], q_q[WIDTH-1:1]};
                    so_d  = q_q[0];
                    cnt_d = cnt_inc;
                end
                ModeAsr: begin
                    q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    so_d  = q_q[0];
                    cnt_d = cnt_inc;
                end
                ModeInv: begin
                    q_d = ~q_q;
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= RESET_VAL;
            so_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            so_q  <= so_d;
            cnt_q <= cnt_d;
        end
    end

    assign q    = q_q;
    assign qn   = ~q_q;
    assign so   = so_q;
    assign cnt  = cnt_q;
    assign full = cnt_sat;

endmodule
